// File: rtl/sd_cmd_rsp_rx.sv
// SD CMD-line response receiver: start-bit hunt, 48/136-bit deserialiser, CRC7 and end-bit check.
// Optional NCR timeout is enabled by defining SDHCI_RSP_TIMEOUT_EN.
module sd_cmd_rsp_rx #(
  parameter int unsigned TimeoutCycles = 64,
  parameter int unsigned CntWidth      = $clog2(TimeoutCycles + 1)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         sample_en_i,
  input  logic         cmd_i,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic         long_rsp_i,
  input  logic         crc_check_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [5:0]   index_o,
  output logic [127:0] rsp_o,
  output logic         crc_err_o,
  output logic         end_err_o,
  output logic         timeout_o
);

  localparam int unsigned ShW      = 127;
  localparam int unsigned BitW     = 8;
  localparam int unsigned CrcW     = 7;
  localparam int unsigned ShortLen = 48;
  localparam int unsigned LongLen  = 136;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    RECV,
    DONE
  } state_t;

  state_t            state_q;
  logic              long_q;
  logic              chk_q;
  logic [ShW-1:0]    shreg_q;
  logic [BitW-1:0]   bit_cnt_q;
  logic [CrcW-1:0]   crc_q;

  logic [BitW-1:0]   bit_num_c;
  logic              crc_fb_c;
  logic [CrcW-1:0]   crc_next_c;
  logic              crc_en_c;
  logic              last_c;
  logic              tmo_hit_c;

  // Number of the bit being captured on this strobe, CRC window and frame end.
  always_comb begin
    bit_num_c  = bit_cnt_q + BitW'(1);
    crc_fb_c   = crc_q[CrcW-1] ^ cmd_i;
    crc_next_c = {crc_q[CrcW-2:0], 1'b0} ^ (crc_fb_c ? CrcW'(7'h09) : CrcW'(0));
    if (long_q) begin
      crc_en_c = (bit_num_c >= BitW'(9)) && (bit_num_c <= BitW'(128));
      last_c   = (bit_num_c == BitW'(LongLen));
    end else begin
      crc_en_c = (bit_num_c <= BitW'(40));
      last_c   = (bit_num_c == BitW'(ShortLen));
    end
  end

`ifdef SDHCI_RSP_TIMEOUT_EN
  logic [CntWidth-1:0] tcnt_q;

  // NCR counter: sampled high bits while hunting for the start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tcnt_q <= '0;
    end else if (!abort_i) begin
      if (state_q == IDLE && start_i) begin
        tcnt_q <= '0;
      end else if (state_q == WAIT_START && sample_en_i && cmd_i) begin
        tcnt_q <= tcnt_q + CntWidth'(1);
      end
    end
  end

  assign tmo_hit_c = (state_q == WAIT_START) && sample_en_i && cmd_i &&
                     (tcnt_q == CntWidth'(TimeoutCycles - 1));
`else
  logic unused_cfg;
  assign unused_cfg = ^CntWidth'(TimeoutCycles);
  assign tmo_hit_c  = 1'b0;
`endif

  // Main receive FSM; every output is a register updated here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      long_q    <= 1'b0;
      chk_q     <= 1'b0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      crc_q     <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      index_o   <= '0;
      rsp_o     <= '0;
      crc_err_o <= 1'b0;
      end_err_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (abort_i) begin
        state_q <= IDLE;
        busy_o  <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              state_q   <= WAIT_START;
              busy_o    <= 1'b1;
              long_q    <= long_rsp_i;
              chk_q     <= crc_check_i;
              shreg_q   <= '0;
              bit_cnt_q <= '0;
              crc_q     <= '0;
              index_o   <= '0;
              rsp_o     <= '0;
              crc_err_o <= 1'b0;
              end_err_o <= 1'b0;
              timeout_o <= 1'b0;
            end
          end
          WAIT_START: begin
            if (sample_en_i) begin
              if (!cmd_i) begin
                state_q   <= RECV;
                bit_cnt_q <= BitW'(1);
                crc_q     <= '0;
              end else if (tmo_hit_c) begin
                state_q   <= DONE;
                busy_o    <= 1'b0;
                done_o    <= 1'b1;
                timeout_o <= 1'b1;
              end
            end
          end
          RECV: begin
            if (sample_en_i) begin
              shreg_q   <= {shreg_q[ShW-2:0], cmd_i};
              bit_cnt_q <= bit_num_c;
              if (crc_en_c) begin
                crc_q <= crc_next_c;
              end
              // shreg_q[i] holds frame bit i+1 when the end bit arrives.
              if (last_c) begin
                state_q   <= DONE;
                busy_o    <= 1'b0;
                done_o    <= 1'b1;
                end_err_o <= ~cmd_i;
                crc_err_o <= chk_q && (crc_q != shreg_q[6:0]);
                if (long_q) begin
                  rsp_o   <= {8'h00, shreg_q[126:7]};
                  index_o <= '0;
                end else begin
                  rsp_o   <= {96'h0, shreg_q[38:7]};
                  index_o <= shreg_q[44:39];
                end
              end
            end
          end
          DONE: begin
            state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_rsp_rx.sv
// Directed bench for sd_cmd_rsp_rx: short/long frames, CRC and end-bit errors, timeout, abort, reset.
module tb_sd_cmd_rsp_rx;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         sample_en_i;
  logic         cmd_i;
  logic         start_i;
  logic         abort_i;
  logic         long_rsp_i;
  logic         crc_check_i;
  logic         busy_o;
  logic         done_o;
  logic [5:0]   index_o;
  logic [127:0] rsp_o;
  logic         crc_err_o;
  logic         end_err_o;
  logic         timeout_o;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  sd_cmd_rsp_rx #(.TimeoutCycles(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sample_en_i(sample_en_i), .cmd_i(cmd_i),
    .start_i(start_i), .abort_i(abort_i), .long_rsp_i(long_rsp_i),
    .crc_check_i(crc_check_i), .busy_o(busy_o), .done_o(done_o),
    .index_o(index_o), .rsp_o(rsp_o), .crc_err_o(crc_err_o),
    .end_err_o(end_err_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (done_o) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One sample_en_i strobe every 4th clock; returns just after the strobe edge.
  task automatic sample(input logic b);
    repeat (3) @(negedge clk_i);
    cmd_i       = b;
    sample_en_i = 1'b1;
    @(negedge clk_i);
    sample_en_i = 1'b0;
    cmd_i       = 1'b1;
  endtask

  task automatic start_rsp(input logic lng, input logic chk);
    @(negedge clk_i);
    start_i     = 1'b1;
    long_rsp_i  = lng;
    crc_check_i = chk;
    @(negedge clk_i);
    start_i     = 1'b0;
  endtask

  task automatic send_frame(input logic [135:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) sample(f[i]);
  endtask

  task automatic idle_highs(input int k);
    for (int i = 0; i < k; i++) sample(1'b1);
  endtask

  task automatic check_pulse(input string tag, input int exp_cnt);
    check({tag, "_done_hi"}, 128'(done_o), 128'd1);
    @(negedge clk_i);
    check({tag, "_done_lo"}, 128'(done_o), 128'd0);
    check({tag, "_done_cnt"}, 128'(done_cnt), 128'(exp_cnt));
    check({tag, "_busy"}, 128'(busy_o), 128'd0);
  endtask

  function automatic logic [6:0] crc7_of(input logic [119:0] d);
    logic [6:0] c;
    logic fb;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      fb = c[6] ^ d[i];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  logic [135:0] fr;
  logic [119:0] body;
  logic [6:0]   lcrc;
  int           dc;

  initial begin
    rst_ni = 1'b0; sample_en_i = 1'b0; cmd_i = 1'b1; start_i = 1'b0;
    abort_i = 1'b0; long_rsp_i = 1'b0; crc_check_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_done", 128'(done_o), 128'd0);
    check("rst_rsp", rsp_o, 128'd0);
    check("rst_flags", 128'({index_o, crc_err_o, end_err_o, timeout_o}), 128'd0);

    // Good short R7 response
    start_rsp(1'b0, 1'b1);
    check("wait_busy", 128'(busy_o), 128'd1);
    idle_highs(5);
    fr = 136'h48_000001AA_87;
    send_frame(fr, 48);
    check_pulse("r7", 1);
    check("r7_index", 128'(index_o), 128'd8);
    check("r7_rsp", rsp_o, 128'h1AA);
    check("r7_err", 128'({crc_err_o, end_err_o, timeout_o}), 128'd0);

    // Last CRC bit flipped, CRC checking on
    start_rsp(1'b0, 1'b1);
    idle_highs(5);
    fr = 136'h48_000001AA_85;
    send_frame(fr, 48);
    check_pulse("badcrc", 2);
    check("badcrc_crc", 128'(crc_err_o), 128'd1);
    check("badcrc_rsp", rsp_o, 128'h1AA);
    check("badcrc_end", 128'(end_err_o), 128'd0);

    // Same frame, CRC checking off
    start_rsp(1'b0, 1'b0);
    idle_highs(5);
    send_frame(fr, 48);
    check_pulse("nochk", 3);
    check("nochk_crc", 128'(crc_err_o), 128'd0);

    // End bit 0
    start_rsp(1'b0, 1'b1);
    idle_highs(5);
    fr = 136'h40_00000000_94;
    send_frame(fr, 48);
    check_pulse("endbit", 4);
    check("endbit_end", 128'(end_err_o), 128'd1);
    check("endbit_crc", 128'(crc_err_o), 128'd0);
    check("endbit_index", 128'(index_o), 128'd0);

    // Long R2 response with good CRC
    body = {15{8'hA5}};
    lcrc = crc7_of(body);
    start_rsp(1'b1, 1'b1);
    idle_highs(3);
    fr = {8'h3F, body, lcrc, 1'b1};
    send_frame(fr, 136);
    check_pulse("r2", 5);
    check("r2_rsp", rsp_o, {8'h00, body});
    check("r2_err", 128'({crc_err_o, end_err_o}), 128'd0);
    check("r2_index", 128'(index_o), 128'd0);

    // Long response with corrupted CRC
    start_rsp(1'b1, 1'b1);
    idle_highs(2);
    fr = {8'h3F, body, lcrc ^ 7'h01, 1'b1};
    send_frame(fr, 136);
    check_pulse("r2bad", 6);
    check("r2bad_crc", 128'(crc_err_o), 128'd1);
    check("r2bad_rsp", rsp_o, {8'h00, body});

    // Start bit never arrives
    start_rsp(1'b0, 1'b1);
`ifdef SDHCI_RSP_TIMEOUT_EN
    idle_highs(63);
    check("tmo_63_done", 128'(done_o), 128'd0);
    check("tmo_63_busy", 128'(busy_o), 128'd1);
    idle_highs(1);
    check("tmo_flag_now", 128'(timeout_o), 128'd1);
    check_pulse("tmo", 7);
    check("tmo_flag", 128'(timeout_o), 128'd1);
    dc = 7;
`else
    idle_highs(1000);
    check("notmo_busy", 128'(busy_o), 128'd1);
    check("notmo_cnt", 128'(done_cnt), 128'd6);
    check("notmo_flag", 128'(timeout_o), 128'd0);
    @(negedge clk_i); abort_i = 1'b1;
    @(negedge clk_i); abort_i = 1'b0;
    check("notmo_abort_busy", 128'(busy_o), 128'd0);
    dc = 6;
`endif
    check("tmo_cleared", 128'({crc_err_o, end_err_o}), 128'd0);
    check("tmo_rsp_cleared", rsp_o, 128'd0);

    // Abort at bit 20, then a clean frame with a stray start_i mid-RECV
    start_rsp(1'b0, 1'b1);
    idle_highs(5);
    fr = 136'h40_00000000_95;
    for (int i = 47; i > 28; i--) sample(fr[i]);
    abort_i = 1'b1;
    sample(fr[28]);
    abort_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check("abort_busy", 128'(busy_o), 128'd0);
    check("abort_cnt", 128'(done_cnt), 128'(dc));
    start_rsp(1'b0, 1'b1);
    idle_highs(4);
    fr = 136'h48_000001AA_87;
    for (int i = 47; i >= 0; i--) begin
      if (i == 30) start_i = 1'b1;
      sample(fr[i]);
      start_i = 1'b0;
    end
    check_pulse("post_abort", dc + 1);
    check("post_abort_index", 128'(index_o), 128'd8);
    check("post_abort_rsp", rsp_o, 128'h1AA);
    check("post_abort_crc", 128'(crc_err_o), 128'd0);

    // Asynchronous reset mid-frame
    start_rsp(1'b0, 1'b1);
    idle_highs(2);
    for (int i = 47; i > 39; i--) sample(fr[i]);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_busy", 128'(busy_o), 128'd0);
    check("arst_rsp", rsp_o, 128'd0);
    check("arst_index", 128'(index_o), 128'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    start_rsp(1'b0, 1'b1);
    idle_highs(1);
    send_frame(fr, 48);
    check_pulse("arst_rec", dc + 2);
    check("arst_rec_index", 128'(index_o), 128'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
